// File: rtl/sipo_pkg.sv
// Shared constants and helpers for the SIPO deframer.
// SIPO_DEFRAMER_PARITY_EN appends one even-parity bit to every frame.
package sipo_pkg;

`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned frame_len(input int unsigned width);
    return width + PARITY_BITS;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned FRAME_LEN = frame_len(DEFAULT_WIDTH);

  typedef logic [cnt_width(DEFAULT_WIDTH)-1:0] cnt_t;

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register with drop detection and a sticky overflow flag.
module sipo_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_perr,
  input  logic             ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overflow,
  output logic             perr
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             perr_q, perr_d;
  logic             accept;
  logic             drop;

  assign accept = load && (!valid_q || ready);
  assign drop   = load && valid_q && !ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    if (accept) begin
      data_d  = load_data;
      perr_d  = load_perr;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    // A drop wins over a simultaneous clear so no loss goes unreported.
    ovf_d = drop || (ovf_q && !ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      perr_q  <= perr_d;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign perr     = perr_q;

endmodule

// File: rtl/sipo_deframer.sv
// MSB-first serial-to-parallel deframer with SYNC realignment and one-word output buffer.
// Build option SIPO_DEFRAMER_PARITY_EN: frames carry a trailing even-parity bit checked on O_PERR.
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             SI,
  input  logic             SI_VALID,
  input  logic             SYNC,
  output logic [WIDTH-1:0] O,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic             OVERFLOW,
  input  logic             OVF_CLR,
  output logic             O_PERR
);

  localparam int unsigned FrameLen = frame_len(WIDTH);
  localparam int unsigned CntW     = cnt_width(WIDTH);
  // Only bits that precede the final frame bit need storage.
  localparam int unsigned ShW      = FrameLen - 1;

  logic [ShW-1:0]   sh_q, sh_d, sh_shift;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             word_perr;

  if (ShW == 1) begin : g_sh_one
    assign sh_shift = SI;
  end else begin : g_sh_many
    assign sh_shift = {sh_q[ShW-2:0], SI};
  end

  assign complete = SI_VALID && !SYNC && (cnt_q == CntW'(FrameLen - 1));

`ifdef SIPO_DEFRAMER_PARITY_EN
  assign word      = sh_q;
  assign word_perr = ^{sh_q, SI};
`else
  assign word      = {sh_q, SI};
  assign word_perr = 1'b0;
`endif

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (SI_VALID) begin
      sh_d = sh_shift;
    end
    // Stale bits left in sh_q after SYNC shift out before the next completion.
    if (SYNC) begin
      cnt_d = SI_VALID ? CntW'(1) : '0;
    end else if (SI_VALID) begin
      cnt_d = complete ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (CLK),
    .rst_n     (RESETN),
    .load      (complete),
    .load_data (word),
    .load_perr (word_perr),
    .ready     (O_READY),
    .ovf_clr   (OVF_CLR),
    .data      (O),
    .valid     (O_VALID),
    .overflow  (OVERFLOW),
    .perr      (O_PERR)
  );

endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer (WIDTH=8) with an in-order output scoreboard.
module tb_sipo_deframer;

  localparam int unsigned W = 8;
`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic         SI = 1'b0;
  logic         SI_VALID = 1'b0;
  logic         SYNC = 1'b0;
  logic [W-1:0] O;
  logic         O_VALID;
  logic         O_READY = 1'b0;
  logic         OVERFLOW;
  logic         OVF_CLR = 1'b0;
  logic         O_PERR;

  int n_cmp = 0;
  int n_err = 0;

  // {perr, data} of each word the consumer is expected to take, in order.
  logic [W:0] sb_q[$];

  sipo_deframer #(
    .WIDTH (W)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .SI       (SI),
    .SI_VALID (SI_VALID),
    .SYNC     (SYNC),
    .O        (O),
    .O_VALID  (O_VALID),
    .O_READY  (O_READY),
    .OVERFLOW (OVERFLOW),
    .OVF_CLR  (OVF_CLR),
    .O_PERR   (O_PERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic inj);
`ifdef SIPO_DEFRAMER_PARITY_EN
    return {7'b0, d, (^d) ^ inj};
`else
    return {8'b0, d} ^ {15'b0, inj & 1'b0};
`endif
  endfunction

  // Sends b[n-1] down to b[0]; returns one time unit after the last sampling edge.
  task automatic send_bits(input logic [15:0] b, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      SI = b[i];
      SI_VALID = 1'b1;
      @(posedge CLK);
      #1;
      SI_VALID = 1'b0;
      if (gap) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic send_word(input logic [7:0] d, input bit gap, input logic inj);
    send_bits(frame_bits(d, inj), FL, gap);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge CLK);
      #1;
    end
    check("drain", sb_q.size(), 0);
  endtask

  always @(negedge CLK) begin
    logic [W:0] exp;
    if (RESETN && O_VALID && O_READY) begin
      if (sb_q.size() == 0) begin
        check("unexpected_word", O_VALID, 0);
      end else begin
        exp = sb_q.pop_front();
        check("out_data", O, exp[W-1:0]);
        check("out_perr", O_PERR, exp[W]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] fb;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_o", O, 0);
    check("rst_valid", O_VALID, 0);
    check("rst_ovf", OVERFLOW, 0);
    check("rst_perr", O_PERR, 0);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Continuous word, visible right after the last bit's edge.
    O_READY = 1'b1;
    sb_q.push_back({1'b0, 8'hB2});
    send_word(8'hB2, 1'b0, 1'b0);
    check("asm_o", O, 8'hB2);
    check("asm_valid", O_VALID, 1);
    check("asm_ovf", OVERFLOW, 0);
    wait_drain();

    // Gapped bits, then two back-to-back words.
    sb_q.push_back({1'b0, 8'hB2});
    send_word(8'hB2, 1'b1, 1'b0);
    wait_drain();
    sb_q.push_back({1'b0, 8'hB2});
    sb_q.push_back({1'b0, 8'h5A});
    send_word(8'hB2, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    check("b2b_o", O, 8'h5A);
    wait_drain();
    check("b2b_ovf", OVERFLOW, 0);

    // Held word consumed on the same edge the next one completes.
    O_READY = 1'b0;
    sb_q.push_back({1'b0, 8'hA5});
    send_word(8'hA5, 1'b0, 1'b0);
    sb_q.push_back({1'b0, 8'h3C});
    fb = frame_bits(8'h3C, 1'b0);
    send_bits(fb >> 1, FL - 1, 1'b0);
    O_READY = 1'b1;
    send_bits(fb, 1, 1'b0);
    check("nobub_o", O, 8'h3C);
    check("nobub_valid", O_VALID, 1);
    check("nobub_ovf", OVERFLOW, 0);
    wait_drain();

    // Back-pressure drops the second word.
    O_READY = 1'b0;
    sb_q.push_back({1'b0, 8'h11});
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    check("bp_o", O, 8'h11);
    check("bp_valid", O_VALID, 1);
    check("bp_ovf", OVERFLOW, 1);
    O_READY = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_consumed", O_VALID, 0);
    check("bp_o_kept", O, 8'h11);
    OVF_CLR = 1'b1;
    @(posedge CLK);
    #1;
    OVF_CLR = 1'b0;
    check("ovf_clr", OVERFLOW, 0);

    // Drop and clear in the same cycle: flag stays set.
    O_READY = 1'b0;
    sb_q.push_back({1'b0, 8'h44});
    send_word(8'h44, 1'b0, 1'b0);
    fb = frame_bits(8'h55, 1'b0);
    send_bits(fb >> 1, FL - 1, 1'b0);
    OVF_CLR = 1'b1;
    send_bits(fb, 1, 1'b0);
    OVF_CLR = 1'b0;
    check("ovf_setdom", OVERFLOW, 1);
    check("setdom_o", O, 8'h44);
    O_READY = 1'b1;
    @(posedge CLK);
    #1;
    OVF_CLR = 1'b1;
    @(posedge CLK);
    #1;
    OVF_CLR = 1'b0;
    check("ovf_clr2", OVERFLOW, 0);
    wait_drain();

    // SYNC realignment discards three stale bits.
    sb_q.push_back({1'b0, 8'h81});
    send_bits(16'b101, 3, 1'b0);
    SYNC = 1'b1;
    send_bits(16'h1, 1, 1'b0);
    SYNC = 1'b0;
    fb = frame_bits(8'h81, 1'b0);
    send_bits(fb, FL - 1, 1'b0);
    check("sync_o", O, 8'h81);
    check("sync_valid", O_VALID, 1);
    wait_drain();

    // Asynchronous reset mid-word with a held word.
    O_READY = 1'b0;
    sb_q.push_back({1'b0, 8'h33});
    send_word(8'h33, 1'b0, 1'b0);
    check("hold_33", O, 8'h33);
    send_bits(16'b10101, 5, 1'b0);
    #3;
    RESETN = 1'b0;
    #1;
    check("arst_o", O, 0);
    check("arst_valid", O_VALID, 0);
    sb_q.delete();
    @(posedge CLK);
    #1;
    RESETN = 1'b1;
    O_READY = 1'b1;
    sb_q.push_back({1'b0, 8'hC3});
    send_word(8'hC3, 1'b0, 1'b0);
    check("post_rst_o", O, 8'hC3);
    wait_drain();

`ifdef SIPO_DEFRAMER_PARITY_EN
    sb_q.push_back({1'b0, 8'hB2});
    send_word(8'hB2, 1'b0, 1'b0);
    check("par_ok", O_PERR, 0);
    wait_drain();
    sb_q.push_back({1'b1, 8'hB2});
    send_word(8'hB2, 1'b0, 1'b1);
    check("par_err", O_PERR, 1);
    wait_drain();
`endif

    check("final_ovf", OVERFLOW, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
